// File: rtl/pwm_pkg.sv
// ============================================================================
// Module  : pwm_pkg
// Purpose : Shared types for the multi-channel PWM generator: counter
//           direction, alignment mode and a per-channel duty word type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  // Counter direction; edge-aligned mode always runs DIR_UP.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  // Alignment mode of the shared period counter.
  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  // Default counter/duty width and the matching per-channel duty word.
  localparam int unsigned PWM_CNT_W_DEF = 8;
  typedef logic [PWM_CNT_W_DEF-1:0] duty_t;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_channel_cmp.sv
// ============================================================================
// Module  : pwm_channel_cmp
// Purpose : One PWM channel. Registers (cnt < duty) while enabled.
//           With PWM_DEADTIME_EN defined it also produces the complementary
//           output and delays every rising output edge by dead_time cycles.
// Ports   : clk, rst_n      - clock, synchronous active-low reset
//           en              - counter run enable (low forces output low)
//           cnt, duty       - shared period count and this channel's duty
//           dead_time       - (PWM_DEADTIME_EN) dead-time length in cycles
//           pwm_out         - registered PWM output
//           pwm_out_n       - (PWM_DEADTIME_EN) registered complementary output
// Config  : PWM_DEADTIME_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_channel_cmp
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
`ifdef PWM_DEADTIME_EN
  ,
  parameter int unsigned DEAD_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
`ifdef PWM_DEADTIME_EN
  input  logic [DEAD_W-1:0] dead_time,
  output logic              pwm_out_n,
`endif
  output logic             pwm_out
);

  logic raw_d;

  // Unsigned compare: duty 0 never matches, duty above the period always does.
  always_comb begin
    raw_d = en && (cnt < duty);
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [DEAD_W-1:0] c_dead_one = DEAD_W'(1);

  logic              raw_q;
  logic [DEAD_W-1:0] dt_d, dt_q;
  logic              pwm_d, pwm_q;
  logic              pwm_n_d, pwm_n_q;

  // Every raw transition reloads the dead-time counter; both outputs stay low
  // until it drains, so a raw pulse shorter than dead_time never appears.
  always_comb begin
    if (raw_d != raw_q) begin
      dt_d = dead_time;
    end else if (dt_q != '0) begin
      dt_d = dt_q - c_dead_one;
    end else begin
      dt_d = '0;
    end
    pwm_d   = raw_d && (dt_d == '0);
    pwm_n_d = !raw_d && (dt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_q   <= 1'b0;
      dt_q    <= '0;
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      raw_q   <= raw_d;
      dt_q    <= dt_d;
      pwm_q   <= pwm_d;
      pwm_n_q <= pwm_n_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign pwm_out_n = pwm_n_q;
`else
  logic pwm_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= raw_d;
    end
  end

  assign pwm_out = pwm_q;
`endif

endmodule : pwm_channel_cmp

`default_nettype wire

// File: rtl/pwm_multi_channel.sv
// ============================================================================
// Module  : pwm_multi_channel
// Purpose : NUM_CH-channel PWM generator sharing one period counter.
//           Edge- or center-aligned, runtime period, shadowed config that is
//           applied only at period boundaries.
// Ports   : clk, rst_n      - clock, synchronous active-low reset
//           en              - counter run enable
//           cfg_valid/ready - config handshake (one pending set at most)
//           cfg_period      - terminal count P
//           cfg_center      - 1 = center-aligned, 0 = edge-aligned
//           cfg_duty        - packed per-channel duty, ch i at [i*CNT_W +: CNT_W]
//           dead_time       - (PWM_DEADTIME_EN) shadowed dead-time length
//           pwm_out         - registered PWM outputs
//           pwm_out_n       - (PWM_DEADTIME_EN) complementary outputs
//           period_tick     - pulse aligned with first output cycle of a period
// Config  : PWM_DEADTIME_EN adds dead-time insertion and pwm_out_n.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
`ifdef PWM_DEADTIME_EN
  ,
  parameter int unsigned DEAD_W = 4
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic                    cfg_center,
  input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
`ifdef PWM_DEADTIME_EN
  input  logic [DEAD_W-1:0]       dead_time,
  output logic [NUM_CH-1:0]       pwm_out_n,
`endif
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // Counter state; the FSM state is {mode_act_q, dir_q}.
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  cnt_dir_e                dir_d, dir_q;
  logic                    tick_d, tick_q;

  // Active (in use) and pending (shadow) configuration.
  logic [CNT_W-1:0]        period_act_d, period_act_q;
  pwm_mode_e               mode_act_d, mode_act_q;
  logic [NUM_CH*CNT_W-1:0] duty_act_d, duty_act_q;
  logic [CNT_W-1:0]        period_pnd_d, period_pnd_q;
  pwm_mode_e               mode_pnd_d, mode_pnd_q;
  logic [NUM_CH*CNT_W-1:0] duty_pnd_d, duty_pnd_q;
  logic                    pnd_vld_d, pnd_vld_q;
`ifdef PWM_DEADTIME_EN
  logic [DEAD_W-1:0]       dead_act_d, dead_act_q;
  logic [DEAD_W-1:0]       dead_pnd_d, dead_pnd_q;
`endif

  logic boundary;
  logic apply;
  logic accept;

  always_comb begin
    // While disabled every edge counts as a boundary so pending config lands.
    if (!en) begin
      boundary = 1'b1;
    end else if (mode_act_q == MODE_EDGE) begin
      boundary = (cnt_q == period_act_q);
    end else begin
      boundary = (period_act_q == '0) || ((dir_q == DIR_DOWN) && (cnt_q == c_cnt_one));
    end
    apply  = boundary && pnd_vld_q;
    // Mutually exclusive with apply: accept needs pnd_vld_q low.
    accept = cfg_valid && !pnd_vld_q;

    period_act_d = period_act_q;
    mode_act_d   = mode_act_q;
    duty_act_d   = duty_act_q;
    period_pnd_d = period_pnd_q;
    mode_pnd_d   = mode_pnd_q;
    duty_pnd_d   = duty_pnd_q;
    pnd_vld_d    = pnd_vld_q;
`ifdef PWM_DEADTIME_EN
    dead_act_d   = dead_act_q;
    dead_pnd_d   = dead_pnd_q;
`endif

    if (accept) begin
      period_pnd_d = cfg_period;
      mode_pnd_d   = cfg_center ? MODE_CENTER : MODE_EDGE;
      duty_pnd_d   = cfg_duty;
      pnd_vld_d    = 1'b1;
`ifdef PWM_DEADTIME_EN
      dead_pnd_d   = dead_time;
`endif
    end

    if (apply) begin
      period_act_d = period_pnd_q;
      mode_act_d   = mode_pnd_q;
      duty_act_d   = duty_pnd_q;
      pnd_vld_d    = 1'b0;
`ifdef PWM_DEADTIME_EN
      dead_act_d   = dead_pnd_q;
`endif
    end

    // Every period (and every mode change) restarts at cnt=0 counting up.
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (boundary) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (mode_act_q == MODE_EDGE) begin
      cnt_d = cnt_q + c_cnt_one;
      dir_d = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      cnt_d = cnt_q + c_cnt_one;
      if (cnt_q == (period_act_q - c_cnt_one)) begin
        dir_d = DIR_DOWN;
      end
    end else begin
      cnt_d = cnt_q - c_cnt_one;
    end

    // cnt==0 only ever occurs as the first count of a period, so its
    // registered copy lines up with the first output cycle of that period.
    tick_d = en && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      tick_q       <= 1'b0;
      period_act_q <= '0;
      mode_act_q   <= MODE_EDGE;
      duty_act_q   <= '0;
      period_pnd_q <= '0;
      mode_pnd_q   <= MODE_EDGE;
      duty_pnd_q   <= '0;
      pnd_vld_q    <= 1'b0;
`ifdef PWM_DEADTIME_EN
      dead_act_q   <= '0;
      dead_pnd_q   <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      tick_q       <= tick_d;
      period_act_q <= period_act_d;
      mode_act_q   <= mode_act_d;
      duty_act_q   <= duty_act_d;
      period_pnd_q <= period_pnd_d;
      mode_pnd_q   <= mode_pnd_d;
      duty_pnd_q   <= duty_pnd_d;
      pnd_vld_q    <= pnd_vld_d;
`ifdef PWM_DEADTIME_EN
      dead_act_q   <= dead_act_d;
      dead_pnd_q   <= dead_pnd_d;
`endif
    end
  end

  assign cfg_ready   = !pnd_vld_q;
  assign period_tick = tick_q;

  for (genvar gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
    pwm_channel_cmp #(
      .CNT_W (CNT_W)
`ifdef PWM_DEADTIME_EN
      ,
      .DEAD_W(DEAD_W)
`endif
    ) u_cmp (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .cnt      (cnt_q),
      .duty     (duty_act_q[gi*CNT_W +: CNT_W]),
`ifdef PWM_DEADTIME_EN
      .dead_time(dead_act_q),
      .pwm_out_n(pwm_out_n[gi]),
`endif
      .pwm_out  (pwm_out[gi])
    );
  end

endmodule : pwm_multi_channel

`default_nettype wire
